imem_loader: RTL and testbench
==============================

# imem_loader

Byte-stream program loader that writes 32-bit words into the instruction memory's write port while the RISC-V core is held stopped. It sits between a byte source (UART receiver or testbench) and the instruction memory, and releases the core through `cpu_run` only after a complete, checksum-verified image has been written. It is the writer for the instruction memory, which the core only reads.

## Interface
- `DEPTH`, default 512: instruction memory depth in words.
- `AW`, default 9: word-address width; it must satisfy 2^AW >= DEPTH.
- `clk`  in  1  clock; all logic is on the rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `start`  in  1  single-cycle request to begin a load; honoured only in IDLE, DONE or ERR.
- `byte_valid`  in  1  the source presents `byte_data`.
- `byte_data`  in  8  stream byte.
- `byte_ready`  out  1  the loader accepts a byte this cycle.
- `imem_we`  out  1  instruction memory write strobe, one cycle wide.
- `imem_addr`  out  AW  word address (matches the core's word-indexed PC).
- `imem_wdata`  out  32  assembled instruction word.
- `cpu_run`  out  1  1 releases the core; 0 holds it.
- `busy`  out  1  a load is in progress (HDR0 through CHK).
- `done`  out  1  level; the last load succeeded.
- `err`  out  1  level; the last load failed.

## Operation
- **Stream format.** The stream has three parts:
  - A 16-bit word count N, sent little-endian (low byte first).
  - N words of 4 bytes each, little-endian.
  - One checksum byte equal to the XOR of all 4N data bytes. Header bytes are excluded from the checksum.
- **Byte acceptance.** A byte is accepted on a rising edge where `byte_valid` and `byte_ready` are both 1.
- **States and transitions:**
  - IDLE: waits for `start`, then moves to HDR0.
  - HDR0: accepts the count low byte.
  - HDR1: accepts the count high byte. Then:
    - N > DEPTH: go to ERR.
    - N = 0: go to CHK; the expected checksum is 0x00.
    - Otherwise: go to DATA.
  - DATA: accepts bytes into `imem_wdata[8*k +: 8]`, with k = 0..3. After the 4th byte it moves to WRITE.
  - WRITE: asserts `imem_we` for exactly one cycle with the current `imem_addr`, then increments the word index. Next state is CHK if the index has reached N, otherwise DATA.
  - CHK: accepts one byte. If it equals the running XOR, go to DONE; otherwise go to ERR.
  - DONE: `cpu_run` = 1 and `done` = 1.
  - ERR: `err` = 1 and `cpu_run` = 0.
- **`byte_ready`** is 1 only in HDR0, HDR1, DATA and CHK.
- **`start` handling:**
  - In DONE or ERR, `start` clears `done`, `err` and `cpu_run` on the same edge and enters HDR0.
  - In any busy state, `start` is ignored.
- **Address and checksum registers.** The word index, byte counter k and running XOR all clear on entry to HDR0. Addresses always begin at 0.
- **`imem_wdata`** holds its value outside WRITE; only its value during WRITE is meaningful.
- **Word count arithmetic.** N is a 16-bit unsigned value, compared against DEPTH before any write. An image of N = DEPTH words fills addresses 0..DEPTH-1 and the index never wraps.
- **Partial image on failure.** Words written before an ERR remain in memory; the core stays held.

## Timing
- **Reset.** `rst_n` = 0 at a rising edge puts the block in IDLE with every output 0: `byte_ready`, `imem_we`, `imem_addr`, `imem_wdata`, `cpu_run`, `busy`, `done`, `err`. The running XOR and the counters also clear.
- **Reset mid-load.** The load is abandoned with no further writes; the core stays held.
- **`busy`** rises on the edge that accepts `start` and falls on the edge entering DONE or ERR.
- **Write latency.** `imem_we` is high in the cycle immediately after the edge that accepts a word's 4th byte. `byte_ready` is 0 during that cycle, so there is one bubble per word.
- **Throughput.** Maximum rate is 4 bytes per 5 cycles in DATA.
- **`cpu_run` release.** `cpu_run` rises on the edge following the accepted checksum byte, when the checksum matches.
- **Source stalls.** `byte_valid` low stalls any state indefinitely with no timeout. Gaps between bytes do not change the outcome.

## Test plan
- **Nominal load.** Reset, then `start`, then send 03 00, 13 01 00 00, 93 00 40 00, 93 01 10 00, 43.
  - Expect writes addr0 = 0x00000113, addr1 = 0x00400093, addr2 = 0x00100193, with `imem_we` exactly 3 cycles high.
  - Then `done` = 1 and `cpu_run` = 1.
- **Bad checksum.** Same stream with checksum 0x42.
  - Expect 3 writes, then `err` = 1, `cpu_run` = 0, `done` = 0.
- **Oversize count.** Count 01 02 (N = 513).
  - Expect ERR after the header, no `imem_we`, and `byte_ready` = 0 afterwards.
- **Zero count.** Count 00 00, checksum 00.
  - Expect `done` with no writes.
  - Checksum 01 instead gives `err`.
- **Stalls and ignored `start`.** Random `byte_valid` gaps during the nominal load, plus `start` pulsed mid-load.
  - Expect identical writes and result to the nominal load; `start` is ignored.
- **Reset and reload.** Assert `rst_n` low after 2 words, then reload the nominal image.
  - Expect outputs 0 during reset, then a correct reload starting at addr 0.
  - After DONE, a new `start` drops `cpu_run` on the same edge.

Source files
------------

// File: rtl/imem_loader.sv
// imem_loader: byte-stream program loader for the instruction memory.
// Stream: 16-bit LE word count N, N LE 32-bit words, XOR checksum of data bytes.
// The core is held (cpu_run_o = 0) until a complete image passes its checksum.
module imem_loader #(
  parameter int DEPTH = 512,
  parameter int AW    = 9
) (
  input  logic          clk_i,
  input  logic          rst_n_i,
  input  logic          start_i,
  input  logic          byte_valid_i,
  input  logic [7:0]    byte_data_i,
  output logic          byte_ready_o,
  output logic          imem_we_o,
  output logic [AW-1:0] imem_addr_o,
  output logic [31:0]   imem_wdata_o,
  output logic          cpu_run_o,
  output logic          busy_o,
  output logic          done_o,
  output logic          err_o
);

  typedef enum logic [2:0] {
    S_IDLE, S_HDR0, S_HDR1, S_DATA, S_WRITE, S_CHK, S_DONE, S_ERR
  } state_e;

  state_e        state_q;
  logic [15:0]   n_q;
  logic [AW-1:0] idx_q;
  logic [1:0]    k_q;
  logic [7:0]    xor_q;
  logic          ready_q, we_q, run_q, busy_q, done_q, err_q;
  logic [31:0]   wdata_q;

  logic          acc_d;
  logic [15:0]   n_hdr_d;
  logic [15:0]   idx_inc_d;

  assign acc_d     = byte_valid_i & ready_q;
  assign n_hdr_d   = {byte_data_i, n_q[7:0]};
  // Widened so that an image of exactly DEPTH words is detected without wrapping.
  assign idx_inc_d = 16'(idx_q) + 16'd1;

  // Loader FSM; every output is a register updated alongside the state.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q <= S_IDLE;
      n_q     <= '0;
      idx_q   <= '0;
      k_q     <= '0;
      xor_q   <= '0;
      ready_q <= 1'b0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      run_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      we_q <= 1'b0;
      case (state_q)
        S_IDLE, S_DONE, S_ERR: begin
          if (start_i) begin
            state_q <= S_HDR0;
            busy_q  <= 1'b1;
            ready_q <= 1'b1;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            run_q   <= 1'b0;
            n_q     <= '0;
            idx_q   <= '0;
            k_q     <= '0;
            xor_q   <= '0;
          end
        end
        S_HDR0: begin
          if (acc_d) begin
            n_q[7:0] <= byte_data_i;
            state_q  <= S_HDR1;
          end
        end
        S_HDR1: begin
          if (acc_d) begin
            n_q <= n_hdr_d;
            if (n_hdr_d > 16'(DEPTH)) begin
              // Oversize image is rejected before anything is written.
              state_q <= S_ERR;
              ready_q <= 1'b0;
              busy_q  <= 1'b0;
              err_q   <= 1'b1;
            end else if (n_hdr_d == 16'd0) begin
              state_q <= S_CHK;
            end else begin
              state_q <= S_DATA;
            end
          end
        end
        S_DATA: begin
          if (acc_d) begin
            wdata_q[{k_q, 3'b000} +: 8] <= byte_data_i;
            xor_q <= xor_q ^ byte_data_i;
            k_q   <= k_q + 2'd1;
            if (k_q == 2'd3) begin
              state_q <= S_WRITE;
              ready_q <= 1'b0;
              we_q    <= 1'b1;
            end
          end
        end
        S_WRITE: begin
          ready_q <= 1'b1;
          // Index is held on the last word so the address never wraps.
          if (idx_inc_d == n_q) begin
            state_q <= S_CHK;
          end else begin
            idx_q   <= idx_q + 1'b1;
            state_q <= S_DATA;
          end
        end
        S_CHK: begin
          if (acc_d) begin
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
            if (byte_data_i == xor_q) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
              run_q   <= 1'b1;
            end else begin
              state_q <= S_ERR;
              err_q   <= 1'b1;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign byte_ready_o = ready_q;
  assign imem_we_o    = we_q;
  assign imem_addr_o  = idx_q;
  assign imem_wdata_o = wdata_q;
  assign cpu_run_o    = run_q;
  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign err_o        = err_q;

endmodule

// File: tb/tb_imem_loader.sv
// Testbench for imem_loader: randomized byte streams with a scoreboard of
// expected memory writes and an image-level reference for the load outcome.
module tb_imem_loader;
  localparam int DEPTH = 512;
  localparam int AW    = 9;

  logic          clk = 1'b0;
  logic          rst_n, start, byte_valid;
  logic [7:0]    byte_data;
  logic          byte_ready, imem_we, cpu_run, busy, done, err;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;

  imem_loader #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .start_i(start),
    .byte_valid_i(byte_valid), .byte_data_i(byte_data), .byte_ready_o(byte_ready),
    .imem_we_o(imem_we), .imem_addr_o(imem_addr), .imem_wdata_o(imem_wdata),
    .cpu_run_o(cpu_run), .busy_o(busy), .done_o(done), .err_o(err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [31:0]   data;
  } wr_t;

  wr_t         exp_q[$];
  logic [31:0] img[0:DEPTH-1];
  int          checks = 0;
  int          errors = 0;
  int          wr_cnt = 0;
  int          base   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Present one byte after a random gap; starts and ends on a falling edge.
  task automatic send_byte(input logic [7:0] b, input int gmax);
    int g;
    bit ok;
    g  = (gmax > 0) ? int'($urandom_range(gmax, 0)) : 0;
    ok = 1'b0;
    repeat (g) @(negedge clk);
    byte_valid = 1'b1;
    byte_data  = b;
    for (int t = 0; t < 200; t++) begin
      if (byte_ready) begin
        ok = 1'b1;
        @(posedge clk);
        break;
      end
      @(negedge clk);
    end
    @(negedge clk);
    byte_valid = 1'b0;
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL byte_timeout: byte %0h never accepted", b);
    end
  endtask

  // Build the stream for img[0..n-1] and push the writes the image implies.
  task automatic run_load(input int n, input bit bad, input int gmax,
                          input bit pulse, input int stop_words);
    logic [7:0]  x;
    logic [7:0]  bt;
    logic [15:0] nn;
    wr_t         w;
    base = wr_cnt;
    nn   = n[15:0];
    x    = 8'h00;
    pulse_start();
    send_byte(nn[7:0], gmax);
    send_byte(nn[15:8], gmax);
    if (n > DEPTH) return;
    for (int i = 0; i < n; i++) begin
      if (i == stop_words) return;
      for (int b = 0; b < 4; b++) begin
        bt = img[i][8*b +: 8];
        x  = x ^ bt;
        if (b == 3) begin
          w.addr = i[AW-1:0];
          w.data = img[i];
          exp_q.push_back(w);
        end
        if (pulse && b == 1) pulse_start();
        send_byte(bt, gmax);
      end
    end
    send_byte(bad ? (x ^ 8'h01) : x, gmax);
  endtask

  task automatic check_result(input bit exp_done, input int exp_writes, input string tag);
    bit seen;
    seen = 1'b0;
    for (int t = 0; t < 20; t++) begin
      if (done || err) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: neither done nor err raised", tag);
    end
    chk({tag, "_done"},   done,       exp_done);
    chk({tag, "_err"},    err,        !exp_done);
    chk({tag, "_run"},    cpu_run,    exp_done);
    chk({tag, "_busy"},   busy,       1'b0);
    chk({tag, "_ready"},  byte_ready, 1'b0);
    chk({tag, "_writes"}, wr_cnt - base, exp_writes);
    chk({tag, "_pend"},   exp_q.size(), 0);
  endtask

  task automatic set_nominal();
    img[0] = 32'h0000_0113;
    img[1] = 32'h0040_0093;
    img[2] = 32'h0010_0193;
  endtask

  task automatic check_reset_outs(input string nm);
    chk(nm, {byte_ready, imem_we, imem_addr, imem_wdata, cpu_run, busy, done, err}, 64'd0);
  endtask

  initial begin
    int  n;
    bit  bad;
    wr_t e;
    rst_n      = 1'b0;
    start      = 1'b0;
    byte_valid = 1'b0;
    byte_data  = 8'h00;

    // Monitor: pop one expected write for each imem_we cycle.
    fork
      forever begin
        @(negedge clk);
        if (imem_we === 1'b1) begin
          wr_cnt++;
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_write: addr %0h data %0h with no write expected",
                     imem_addr, imem_wdata);
          end else begin
            e = exp_q.pop_front();
            chk("wr_addr", 64'(imem_addr), 64'(e.addr));
            chk("wr_data", 64'(imem_wdata), 64'(e.data));
          end
        end
      end
    join_none

    repeat (3) @(negedge clk);
    check_reset_outs("reset_outs");
    rst_n = 1'b1;
    @(negedge clk);

    set_nominal();
    run_load(3, 1'b0, 0, 1'b0, -1);
    check_result(1'b1, 3, "nominal");

    run_load(3, 1'b1, 0, 1'b0, -1);
    check_result(1'b0, 3, "badchk");

    run_load(513, 1'b0, 0, 1'b0, -1);
    check_result(1'b0, 0, "oversize");
    repeat (5) @(negedge clk);
    chk("oversize_ready_after", byte_ready, 1'b0);

    run_load(0, 1'b0, 0, 1'b0, -1);
    check_result(1'b1, 0, "zero");
    run_load(0, 1'b1, 0, 1'b0, -1);
    check_result(1'b0, 0, "zero_bad");

    run_load(3, 1'b0, 4, 1'b1, -1);
    check_result(1'b1, 3, "stall");

    for (int r = 0; r < 4; r++) begin
      n   = int'($urandom_range(12, 1));
      bad = ($urandom_range(3, 0) == 0);
      for (int i = 0; i < n; i++) img[i] = $urandom;
      run_load(n, bad, 3, 1'($urandom_range(1, 0)), -1);
      check_result(!bad, n, "rand");
    end

    for (int i = 0; i < DEPTH; i++) img[i] = $urandom;
    run_load(DEPTH, 1'b0, 0, 1'b0, -1);
    check_result(1'b1, DEPTH, "full");

    set_nominal();
    run_load(3, 1'b0, 0, 1'b0, 2);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check_reset_outs("midload_rst_outs");
    @(negedge clk);
    @(negedge clk);
    check_reset_outs("midload_rst_hold");
    chk("midload_pend", exp_q.size(), 0);
    rst_n = 1'b1;
    @(negedge clk);
    run_load(3, 1'b0, 0, 1'b0, -1);
    check_result(1'b1, 3, "reload");

    start = 1'b1;
    @(posedge clk);
    #1;
    chk("restart_run", cpu_run, 1'b0);
    chk("restart_done", done, 1'b0);
    chk("restart_busy", busy, 1'b1);
    chk("restart_ready", byte_ready, 1'b1);
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
